// File: rtl/arb2_pkg.sv
// Shared types for the two-port round-robin arbiter: FSM state, port
// indices and the one-hot grant helper.
package arb2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } arb_state_e;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  // One-hot grant vector for a port index.
  function automatic logic [1:0] onehot2(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/arb2_mux_if.sv
// Bundle of both upstream valid/ready channels, the shared downstream
// channel and the arbiter status (select, grant).
interface arb2_mux_if #(
  parameter int WIDTH = 8
);
  logic             d0_valid;
  logic [WIDTH-1:0] d0_data;
  logic             d0_ready;
  logic             d1_valid;
  logic [WIDTH-1:0] d1_data;
  logic             d1_ready;
  logic             y_valid;
  logic [WIDTH-1:0] y_data;
  logic             y_ready;
  logic             s;
  logic [1:0]       grant;

  // Arbiter side.
  modport slave (
    input  d0_valid, d0_data, d1_valid, d1_data, y_ready,
    output d0_ready, d1_ready, y_valid, y_data, s, grant
  );

  // Producer/consumer side (environment).
  modport master (
    output d0_valid, d0_data, d1_valid, d1_data, y_ready,
    input  d0_ready, d1_ready, y_valid, y_data, s, grant
  );
endinterface

// File: rtl/mux2_w.sv
// WIDTH-bit 2:1 combinational mux for the arbiter payload.
module mux2_w #(
  parameter int WIDTH = 8
) (
  input  logic             s,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] y
);

  // Pure select, no registering: payload latency is zero.
  always_comb y = s ? d1 : d0;

endmodule

// File: rtl/arb2_mux.sv
// Two-requester round-robin arbiter in front of one valid/ready consumer.
// A grant lasts until the owner drops valid or, while the other side is
// waiting, until MAX_HOLD beats have been accepted. The switch happens on
// the accepting edge, so contended traffic flows at one beat per cycle.
module arb2_mux
  import arb2_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input logic         clk,
  input logic         rst,
  arb2_mux_if.slave   bus
);

  localparam int             CW      = $clog2(MAX_HOLD) + 1;
  localparam logic [CW-1:0]  CNT_TOP = CW'(MAX_HOLD - 1);

  arb_state_e    state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s_hold_q;

  logic granted, cur, valid_cur, other_valid, fire, sel;

  // Decode current owner and the handshake of the granted side.
  always_comb begin
    granted     = (state_q != IDLE);
    cur         = (state_q == G1) ? P1 : P0;
    valid_cur   = cur ? bus.d1_valid : bus.d0_valid;
    other_valid = cur ? bus.d0_valid : bus.d1_valid;
    fire        = granted & valid_cur & bus.y_ready;
    // Select follows the owner; when idle it keeps its previous value.
    sel         = granted ? cur : s_hold_q;
  end

  // Channel outputs: readys pass y_ready straight through to the owner.
  always_comb begin
    bus.s        = sel;
    bus.grant    = granted ? onehot2(cur) : 2'b00;
    bus.y_valid  = granted & valid_cur;
    bus.d0_ready = (state_q == G0) & bus.y_ready;
    bus.d1_ready = (state_q == G1) & bus.y_ready;
  end

  mux2_w #(.WIDTH(WIDTH)) u_mux (
    .s  (sel),
    .d0 (bus.d0_data),
    .d1 (bus.d1_data),
    .y  (bus.y_data)
  );

  // Next-state: grant hand-off, release to idle, and hold-count tracking.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.d0_valid && bus.d1_valid) state_d = last_q ? G0 : G1;
        else if (bus.d0_valid)            state_d = G0;
        else if (bus.d1_valid)            state_d = G1;
      end
      G0, G1: begin
        if ((fire && cnt_q == CNT_TOP && other_valid) ||
            (!valid_cur && other_valid)) begin
          // Hold budget spent, or owner went quiet: hand over with no bubble.
          state_d = cur ? G0 : G1;
          cnt_d   = '0;
          last_d  = cur;
        end else if (!valid_cur) begin
          state_d = IDLE;
          cnt_d   = '0;
          last_d  = cur;
        end else if (fire && cnt_q != CNT_TOP) begin
          // Saturate rather than wrap when uncontended.
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; last=1 on reset so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      s_hold_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      s_hold_q <= sel;
    end
  end

endmodule

// File: tb/tb_arb2_mux.sv
// Directed scenarios followed by constrained-random traffic, every cycle
// compared against a rule-level model of who owns the channel.
module tb_arb2_mux;

  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic clk;
  logic rst;

  arb2_mux_if #(.WIDTH(WIDTH)) bus ();

  arb2_mux #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Stimulus currently applied.
  logic             v  [2];
  logic [WIDTH-1:0] dd [2];
  logic             yr;
  logic             r;

  // Reference: owner -1 = nobody, else port index; run = beats in grant.
  int m_owner = -1;
  int m_run   = 0;
  int m_last  = 1;
  int m_shold = 0;
  logic m_fired [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic rr, input logic v0, input logic [WIDTH-1:0] d0,
                       input logic v1, input logic [WIDTH-1:0] d1, input logic yrdy);
    r = rr; v[0] = v0; dd[0] = d0; v[1] = v1; dd[1] = d1; yr = yrdy;
    rst          = r;
    bus.d0_valid = v0; bus.d0_data = d0;
    bus.d1_valid = v1; bus.d1_data = d1;
    bus.y_ready  = yrdy;
    #1;
  endtask

  // Compare all outputs with the model, clock, then advance the model.
  task automatic tick();
    logic ev;
    #2;
    ev = (m_owner >= 0) && v[m_owner];
    chk("y_valid", 32'(bus.y_valid), 32'(ev));
    if (ev) chk("y_data", 32'(bus.y_data), 32'(dd[m_owner]));
    chk("s", 32'(bus.s), (m_owner >= 0) ? m_owner : m_shold);
    chk("grant", 32'(bus.grant), (m_owner >= 0) ? (1 << m_owner) : 0);
    chk("d0_ready", 32'(bus.d0_ready), 32'((m_owner == 0) && yr));
    chk("d1_ready", 32'(bus.d1_ready), 32'((m_owner == 1) && yr));
    @(posedge clk);
    m_fired[0] = 1'b0;
    m_fired[1] = 1'b0;
    if (r) begin
      m_owner = -1; m_run = 0; m_last = 1; m_shold = 0;
    end else if (m_owner < 0) begin
      if (v[0] && v[1]) m_owner = 1 - m_last;
      else if (v[0])    m_owner = 0;
      else if (v[1])    m_owner = 1;
      m_run = 0;
    end else begin
      int x;
      logic f, ov;
      x = m_owner;
      f = v[x] && yr;
      ov = v[1-x];
      m_fired[x] = f;
      m_shold = x;
      if ((f && m_run == MAX_HOLD - 1 && ov) || (!v[x] && ov)) begin
        m_owner = 1 - x; m_run = 0; m_last = x;
      end else if (!v[x]) begin
        m_owner = -1; m_run = 0; m_last = x;
      end else if (f && m_run < MAX_HOLD - 1) begin
        m_run++;
      end
    end
    #1;
  endtask

  task automatic do_reset(input logic v0, input logic v1);
    for (int i = 0; i < 2; i++) begin
      drive(1, v0, 8'h00, v1, 8'h00, 1);
      tick();
    end
  endtask

  initial begin
    r = 1'b1; yr = 1'b0;
    v[0] = 0; v[1] = 0; dd[0] = '0; dd[1] = '0;
    m_fired[0] = 0; m_fired[1] = 0;
    drive(1, 0, 8'h00, 0, 8'h00, 0);
    @(posedge clk); #1;

    // Reset with both requesting.
    do_reset(1, 1);
    drive(1, 1, 8'h11, 1, 8'h22, 1);
    chk("rst_y_valid", 32'(bus.y_valid), 0);
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_s", 32'(bus.s), 0);
    chk("rst_readys", {bus.d0_ready, bus.d1_ready}, 0);
    tick();
    drive(0, 1, 8'h11, 1, 8'h22, 1);
    chk("rel_idle", 32'(bus.grant), 0);
    tick();
    drive(0, 1, 8'h11, 1, 8'h22, 1);
    chk("rel_first_grant", 32'(bus.grant), 32'h1);
    tick();

    // Single source, no switch past MAX_HOLD.
    do_reset(0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 8'hA5, 0, 8'h00, 1);
      if (i == 0) chk("single_bubble", 32'(bus.y_valid), 0);
      else begin
        chk("single_data", 32'(bus.y_data), 32'hA5);
        chk("single_rdy", 32'(bus.d0_ready), 1);
        chk("single_s", 32'(bus.s), 0);
      end
      tick();
    end

    // Contention: 4 beats of port 0, then 4 of port 1, no idle cycles.
    do_reset(0, 0);
    for (int i = 0; i < 17; i++) begin
      drive(0, 1, 8'h3C, 1, 8'hC3, 1);
      if (i > 0) begin
        chk("cont_sel", 32'(bus.s), ((i - 1) / MAX_HOLD) % 2);
        chk("cont_valid", 32'(bus.y_valid), 1);
      end
      tick();
    end

    // Backpressure while port 1 waits.
    do_reset(0, 0);
    drive(0, 1, 8'h5A, 1, 8'h77, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 8'h5A, 1, 8'h77, 0);
      chk("bp_grant", 32'(bus.grant), 32'h1);
      chk("bp_rdy", 32'(bus.d0_ready), 0);
      chk("bp_data", 32'(bus.y_data), 32'h5A);
      tick();
    end
    for (int i = 0; i < MAX_HOLD; i++) begin
      drive(0, 1, 8'h5A, 1, 8'h77, 1);
      chk("bp_hold", 32'(bus.grant), 32'h1);
      tick();
    end
    drive(0, 1, 8'h5A, 1, 8'h77, 1);
    chk("bp_switch", 32'(bus.grant), 32'h2);
    tick();

    // Early release of G1 after 2 beats.
    drive(0, 1, 8'h5A, 1, 8'h78, 1);
    tick();
    drive(0, 1, 8'h5A, 0, 8'h00, 1);
    chk("er_still_g1", 32'(bus.grant), 32'h2);
    chk("er_no_valid", 32'(bus.y_valid), 0);
    tick();
    drive(0, 1, 8'h5A, 0, 8'h00, 1);
    chk("er_g0", 32'(bus.grant), 32'h1);
    chk("er_zero_bubble", 32'(bus.y_valid), 1);
    tick();

    // Reset mid-grant on port 1 with a stalled beat.
    do_reset(0, 0);
    drive(0, 0, 8'h00, 1, 8'h99, 0);
    tick();
    drive(0, 0, 8'h00, 1, 8'h99, 0);
    chk("mr_g1", 32'(bus.grant), 32'h2);
    tick();
    drive(1, 0, 8'h00, 1, 8'h99, 0);
    tick();
    drive(0, 1, 8'h44, 1, 8'h99, 1);
    chk("mr_idle", {bus.y_valid, bus.s, bus.grant}, 0);
    tick();
    drive(0, 1, 8'h44, 1, 8'h99, 1);
    chk("mr_tie_p0", 32'(bus.grant), 32'h1);
    tick();

    // Random traffic; producers hold valid/data until accepted.
    do_reset(0, 0);
    for (int c = 0; c < 1500; c++) begin
      logic nv [2];
      logic [WIDTH-1:0] nd [2];
      for (int p = 0; p < 2; p++) begin
        if (v[p] && !m_fired[p] && !r) begin
          nv[p] = 1'b1; nd[p] = dd[p];
        end else begin
          nv[p] = ($urandom_range(0, 9) < 6);
          nd[p] = WIDTH'($urandom);
        end
      end
      drive(($urandom_range(0, 99) == 0), nv[0], nd[0], nv[1], nd[1],
            ($urandom_range(0, 3) != 0));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
